// File: rtl/vx_tensor_wb_serializer.sv
// vx_tensor_wb_serializer: buffers 4x4 fp32 D tiles and streams them out as row beats.
// Optional macro TENSOR_WB_DUAL_BUF_EN selects a 2-entry tile FIFO instead of one tile register.
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif

module vx_tensor_wb_serializer #(
  parameter int ROWS_PER_BEAT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [3:0][3:0][31:0]        D_tile,
  input  logic [`NW_WIDTH-1:0]         D_wid,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [ROWS_PER_BEAT*128-1:0] data_out,
  output logic [1:0]                   row_idx,
  output logic [`NW_WIDTH-1:0]         wid_out,
  output logic                         last_out,
  output logic                         busy
);
  localparam int NBEATS = 4 / ROWS_PER_BEAT;
  localparam logic [1:0] LAST_BEAT = 2'(NBEATS - 1);

  logic                  w_enq;
  logic                  w_deq;
  logic                  w_release;
  logic                  w_busy;
  logic [3:0][3:0][31:0] w_head_tile;
  logic [`NW_WIDTH-1:0]  w_head_wid;
  logic [1:0]            w_row_base;
  logic [1:0]            r_beat;

  assign w_enq     = valid_in && ready_in;
  assign w_deq     = w_busy && ready_out;
  assign w_release = w_deq && (r_beat == LAST_BEAT);

`ifdef TENSOR_WB_DUAL_BUF_EN
  logic [1:0][3:0][3:0][31:0] r_tile;
  logic [1:0][`NW_WIDTH-1:0]  r_wid;
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_occ;

  assign w_busy      = (r_occ != 2'd0);
  assign ready_in    = (r_occ != 2'd2);
  assign w_head_tile = r_tile[r_rd_ptr];
  assign w_head_wid  = r_wid[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tile   <= '0;
      r_wid    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_enq) begin
        r_tile[r_wr_ptr] <= D_tile;
        r_wid[r_wr_ptr]  <= D_wid;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_release) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_enq && !w_release) begin
        r_occ <= r_occ + 2'd1;
      end else if (!w_enq && w_release) begin
        r_occ <= r_occ - 2'd1;
      end
    end
  end
`else
  logic [3:0][3:0][31:0] r_tile;
  logic [`NW_WIDTH-1:0]  r_wid;
  logic                  r_full;

  // Releasing the last beat frees the register in the same cycle, so a new tile can land back-to-back.
  assign w_busy      = r_full;
  assign ready_in    = !r_full || w_release;
  assign w_head_tile = r_tile;
  assign w_head_wid  = r_wid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tile <= '0;
      r_wid  <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_enq) begin
        r_tile <= D_tile;
        r_wid  <= D_wid;
        r_full <= 1'b1;
      end else if (w_release) begin
        r_full <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat <= 2'd0;
    end else if (w_release) begin
      r_beat <= 2'd0;
    end else if (w_deq) begin
      r_beat <= r_beat + 2'd1;
    end
  end

  always_comb begin
    w_row_base = 2'(int'(r_beat) * ROWS_PER_BEAT);
  end

  // Outputs are forced to zero while idle so the post-reset values are well defined.
  always_comb begin
    data_out = '0;
    if (w_busy) begin
      for (int i = 0; i < ROWS_PER_BEAT; i++) begin
        data_out[i*128 +: 128] = w_head_tile[2'(int'(w_row_base) + i)];
      end
    end
  end

  assign valid_out = w_busy;
  assign busy      = w_busy;
  assign last_out  = w_busy && (r_beat == LAST_BEAT);
  assign row_idx   = w_busy ? w_row_base : 2'd0;
  assign wid_out   = w_busy ? w_head_wid : '0;

endmodule

// File: doc/vx_tensor_wb_serializer.md
VX_TENSOR_WB_SERIALIZER -- requirements
Module: VX_tensor_wb_serializer

Interface
REQ-001 SHALL have parameter ROWS_PER_BEAT, default 1, meaning D-tile rows emitted per output beat; legal values 1, 2, 4.
REQ-002 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port valid_in, input, 1, DPU result valid.
REQ-005 SHALL have port ready_in, output, 1, serializer can accept a tile.
REQ-006 SHALL have port D_tile, input, [3:0][3:0][31:0], 4x4 fp32 result; row r = D_tile[r].
REQ-007 SHALL have port D_wid, input, `NW_WIDTH, warp id of D_tile.
REQ-008 SHALL have port valid_out, output, 1, beat valid.
REQ-009 SHALL have port ready_out, input, 1, writeback accepts beat.
REQ-010 SHALL have port data_out, output, ROWS_PER_BEAT*128, rows row_idx..row_idx+ROWS_PER_BEAT-1; lowest row in LSBs.
REQ-011 SHALL have port row_idx, output, 2, first row index of current beat.
REQ-012 SHALL have port wid_out, output, `NW_WIDTH, warp id of tile being emitted.
REQ-013 SHALL have port last_out, output, 1, current beat is final beat of tile.
REQ-014 SHALL have port busy, output, 1, at least one tile held.

Function
REQ-015 SHALL accept a tile when valid_in && ready_in (enq), storing D_tile and D_wid in an internal tile buffer.
REQ-016 SHALL split each tile into NBEATS = 4/ROWS_PER_BEAT beats; beat k carries rows k*ROWS_PER_BEAT onward; row_idx = k*ROWS_PER_BEAT.
REQ-017 SHALL assert valid_out from a registered buffer: first beat of a tile enqueued at cycle t is valid no earlier than t+1 (no combinational input-to-output path).
REQ-018 SHALL hold data_out, row_idx, wid_out, last_out stable while valid_out && !ready_out.
REQ-019 SHALL advance beat counter on valid_out && ready_out (deq); on deq with last_out=1 counter wraps to 0 and head tile is released.
REQ-020 SHALL assert last_out iff valid_out and beat counter == NBEATS-1; ROWS_PER_BEAT=4 gives last_out on every beat.
REQ-021 SHALL emit tiles in acceptance order; beats of different tiles never interleave.
REQ-022 SHALL, on simultaneous enq and last-beat deq, keep occupancy unchanged and present the next tile's beat 0 in the following cycle with no bubble if a second tile is held.
REQ-023 SHALL drive busy = (occupancy != 0); valid_out = busy.
REQ-024 SHALL ignore D_tile/D_wid when valid_in is low or ready_in is low; no state change.

Reset
REQ-025 SHALL, on reset assertion (asynchronous, any cycle including mid-tile), clear occupancy, beat counter, and all tile storage; partially emitted tiles are discarded.
REQ-026 SHALL reset outputs to: ready_in=1, valid_out=0, busy=0, last_out=0, row_idx=0, data_out=0, wid_out=0.
REQ-027 SHALL accept a tile in the first cycle after reset deassertion.

Configuration
REQ-028 SHALL support macro TENSOR_WB_DUAL_BUF_EN.
REQ-029 With TENSOR_WB_DUAL_BUF_EN defined, SHALL use a 2-entry tile FIFO; ready_in = (occupancy < 2), independent of ready_out.
REQ-030 Without TENSOR_WB_DUAL_BUF_EN, SHALL use a single tile register; ready_in = !busy || (deq && last_out), allowing back-to-back tiles via same-cycle replacement.

Verification
REQ-031 ROWS_PER_BEAT=1, ready_out=1, one tile D_tile[r][c]=32'h100*r+c, wid=3 -> 4 beats, consecutive cycles, row_idx 0,1,2,3, data_out rows 0..3, wid_out=3, last_out only on row_idx=3.
REQ-032 ROWS_PER_BEAT=2, ready_out toggled 1,0,1 -> 2 beats, data_out held during stall, beat 0 = {row1,row0}, last_out on beat 1.
REQ-033 DUAL_BUF_EN, ready_out=0, offer 3 tiles (wid 1,2,3) -> 2 accepted, ready_in=0 thereafter; release ready_out -> 8 beats wid 1 then 2 with no bubble; third tile then accepted.
REQ-034 Without DUAL_BUF_EN, tile A emitting, tile B valid_in on A's last-beat deq -> B accepted same cycle, B beat 0 valid next cycle.
REQ-035 Reset asserted after beat 1 of a tile -> valid_out=0, busy=0, ready_in=1 immediately; no remaining beats emitted after deassertion.
REQ-036 ROWS_PER_BEAT=4, two tiles back-to-back, ready_out=1 -> one beat per tile, last_out=1, row_idx=0 each.
